isa_block_encoder: RTL

Packs per-instruction field bundles into raw 32-bit TRIPS instruction words, using the bit layout the I-tile decoder expects. It is the write-side counterpart of instruction decode and sits between the block loader/assembler path and the I-cache fill port. It tracks the block's instruction index and the implicit LSID/EXIT_ID counters, so that zero ID fields resolve identically at decode time. It also flags blocks that overflow those limits.

---
 rtl/isa_block_encoder_if.sv | 36 +++
 rtl/isa_block_encoder.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/isa_block_encoder_if.sv
// Field-bundle input and encoded-word output handshakes of the TRIPS block encoder.
// master = loader/assembler + I-cache fill side, slave = encoder.
interface isa_block_encoder_if;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_class;
   logic [7:0]  in_opcode;
   logic        in_pred_en;
   logic        in_pred_true;
   logic [4:0]  in_id;
   logic [15:0] in_imm;
   logic [1:0]  in_bit;
   logic [7:0]  in_tgt0;
   logic [7:0]  in_tgt1;
   logic [1:0]  in_slot0;
   logic [1:0]  in_slot1;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_word;
   logic [6:0]  out_index;
   logic        out_last;
   logic        err_overflow;

   modport master (
      output in_valid, in_class, in_opcode, in_pred_en, in_pred_true, in_id, in_imm,
             in_bit, in_tgt0, in_tgt1, in_slot0, in_slot1, in_last, out_ready,
      input  in_ready, out_valid, out_word, out_index, out_last, err_overflow
   );

   modport slave (
      input  in_valid, in_class, in_opcode, in_pred_en, in_pred_true, in_id, in_imm,
             in_bit, in_tgt0, in_tgt1, in_slot0, in_slot1, in_last, out_ready,
      output in_ready, out_valid, out_word, out_index, out_last, err_overflow
   );
endinterface

// File: rtl/isa_block_encoder.sv
// Packs TRIPS instruction field bundles into 32-bit words, tracking per-block
// instruction index and auto LSID/EXIT_ID counters, with a small output FIFO.
module isa_block_encoder #(
   parameter int FIFO_DEPTH = 4,
   parameter int MAX_INSTRS = 128,
   parameter int MAX_EXITS  = 8
) (
   input  logic               clk,
   input  logic               rst,
   isa_block_encoder_if.slave bus
);
   // Class codes mirror the CLASS_* values of trips_isa.svh.
   localparam logic [2:0] CLASS_G = 3'd0;
   localparam logic [2:0] CLASS_L = 3'd2;
   localparam logic [2:0] CLASS_S = 3'd3;
   localparam logic [2:0] CLASS_B = 3'd4;
   localparam logic [2:0] CLASS_C = 3'd5;

   localparam int         AW       = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_ERR} state_t;

   state_t        r_state;
   logic [7:0]    r_instr_cnt;
   logic [5:0]    r_lsid_cnt;
   logic [3:0]    r_exit_cnt;
   logic          r_err;

   logic [31:0]   r_mem_word [FIFO_DEPTH];
   logic [6:0]    r_mem_idx  [FIFO_DEPTH];
   logic          r_mem_last [FIFO_DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;

   logic          w_full, w_empty, w_acc, w_pop, w_push;
   logic          w_ls_auto, w_b_auto, w_ovf;
   logic [31:0]   w_word;

   assign w_full  = (r_count == FULL_CNT);
   assign w_empty = (r_count == '0);

   assign bus.in_ready = (r_state == S_ERR) | ~w_full;
   assign w_acc        = bus.in_valid & bus.in_ready;
   assign w_pop        = ~w_empty & bus.out_ready;

   assign w_ls_auto = ((bus.in_class == CLASS_L) | (bus.in_class == CLASS_S)) & (bus.in_id == 5'd0);
   assign w_b_auto  = (bus.in_class == CLASS_B) & (bus.in_id == 5'd0);

   // Limits are checked against the counts before this accept.
   assign w_ovf  = (r_instr_cnt == 8'(MAX_INSTRS))
                 | (w_ls_auto & (r_lsid_cnt == 6'd32))
                 | (w_b_auto  & (r_exit_cnt == 4'(MAX_EXITS)));
   assign w_push = w_acc & (r_state != S_ERR) & ~w_ovf;

   always_comb begin
      w_word        = '0;
      w_word[28]    = bus.in_pred_en;
      w_word[27]    = bus.in_pred_en & bus.in_pred_true;
      w_word[26:24] = bus.in_class;
      case (bus.in_class)
         CLASS_G:
            w_word[23:0] = {bus.in_tgt1, bus.in_tgt0, bus.in_opcode[7:4], bus.in_slot1, bus.in_slot0};
         CLASS_L, CLASS_S, CLASS_B:
            // Auto IDs go out as 0 so the decoder substitutes its own matching counter.
            w_word[23:0] = {bus.in_id, bus.in_imm[10:0], bus.in_opcode};
         CLASS_C:
            w_word[23:0] = {2'b00, bus.in_bit, bus.in_imm[11:0], bus.in_opcode};
         default:
            w_word[23:0] = {bus.in_imm, bus.in_opcode};
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_instr_cnt <= '0;
         r_lsid_cnt  <= '0;
         r_exit_cnt  <= '0;
         r_err       <= 1'b0;
      end else if (w_acc) begin
         case (r_state)
            S_IDLE, S_ACTIVE: begin
               if (w_ovf) r_err <= 1'b1;
               if (bus.in_last) begin
                  r_state     <= S_IDLE;
                  r_instr_cnt <= '0;
                  r_lsid_cnt  <= '0;
                  r_exit_cnt  <= '0;
               end else if (w_ovf) begin
                  r_state <= S_ERR;
               end else begin
                  r_state     <= S_ACTIVE;
                  r_instr_cnt <= r_instr_cnt + 8'd1;
                  r_lsid_cnt  <= r_lsid_cnt + {5'd0, w_ls_auto};
                  r_exit_cnt  <= r_exit_cnt + {3'd0, w_b_auto};
               end
            end
            S_ERR: begin
               if (bus.in_last) begin
                  r_state     <= S_IDLE;
                  r_instr_cnt <= '0;
                  r_lsid_cnt  <= '0;
                  r_exit_cnt  <= '0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_mem_word[r_wr_ptr] <= w_word;
            r_mem_idx[r_wr_ptr]  <= r_instr_cnt[6:0];
            r_mem_last[r_wr_ptr] <= bus.in_last;
            r_wr_ptr             <= r_wr_ptr + 1'b1;
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Head outputs are forced to zero while empty so reset leaves them clean.
   assign bus.out_valid    = ~w_empty;
   assign bus.out_word     = w_empty ? 32'd0 : r_mem_word[r_rd_ptr];
   assign bus.out_index    = w_empty ? 7'd0  : r_mem_idx[r_rd_ptr];
   assign bus.out_last     = ~w_empty & r_mem_last[r_rd_ptr];
   assign bus.err_overflow = r_err;
endmodule
